// File: rtl/mips_regfile_pkg.sv
// Shared MIPS datapath types and constants: register indices, word type, default widths.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_regfile_if.sv
// Register-file access bundle: one write port and two read ports.
interface mips_regfile_if #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) ();

    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2,
        input  read_data1, read_data2
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2,
        output read_data1, read_data2
    );

endinterface

// File: rtl/mips_regfile_read_port.sv
// One combinational read port: $zero and rst force 0; write-before-read bypass under REGFILE_BYPASS_EN.
module regfile_read_port #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              rst,
    input  logic [DATA_W-1:0] regs [1 << ADDR_W],
    input  logic [ADDR_W-1:0] read_reg,
`ifdef REGFILE_BYPASS_EN
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
`endif
    output logic [DATA_W-1:0] read_data
);

    // A nonzero read_reg matching write_reg implies write_reg is nonzero too.
    always_comb begin
        read_data = '0;
        if (rst || read_reg == '0)
            read_data = '0;
`ifdef REGFILE_BYPASS_EN
        else if (reg_write && write_reg == read_reg)
            read_data = write_data;
`endif
        else
            read_data = regs[read_reg];
    end

endmodule

// File: rtl/mips_regfile.sv
// 32x32 MIPS register file, two async read ports and one sync write port.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module mips_regfile #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
    input logic           clk,
    input logic           rst,
    mips_regfile_if.slave bus
);

    import mips_pkg::*;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk) begin
        if (rst)
            regs <= '{default: '0};
        else if (bus.reg_write && bus.write_reg != '0)
            regs[bus.write_reg] <= bus.write_data;
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
        .rst        (rst),
        .regs       (regs),
        .read_reg   (bus.read_reg1),
`ifdef REGFILE_BYPASS_EN
        .reg_write  (bus.reg_write),
        .write_reg  (bus.write_reg),
        .write_data (bus.write_data),
`endif
        .read_data  (bus.read_data1)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
        .rst        (rst),
        .regs       (regs),
        .read_reg   (bus.read_reg2),
`ifdef REGFILE_BYPASS_EN
        .reg_write  (bus.reg_write),
        .write_reg  (bus.write_reg),
        .write_data (bus.write_data),
`endif
        .read_data  (bus.read_data2)
    );

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: vector table, fill/reset sequence, random model phase.
module tb_mips_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct packed {
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_regfile_if bus ();

    mips_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb [$];
    vec_t        tbl [19];
    logic [31:0] model [32];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(input logic r, input logic rw, input logic [4:0] wr,
                                input logic [31:0] wd, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [31:0] e1,
                                input logic [31:0] e2);
        vec_t v;
        v.rst = r; v.rw = rw; v.wr = wr; v.wd = wd;
        v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    function automatic logic [31:0] pick(input logic [31:0] bypassed, input logic [31:0] stored);
        return BYP ? bypassed : stored;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic r,
                                               input logic rw, input logic [4:0] wr,
                                               input logic [31:0] wd);
        if (r || idx == 5'd0) return 32'h0;
        if (BYP && rw && wr == idx) return wd;
        return model[idx];
    endfunction

    function automatic logic [31:0] fill_val(input int i);
        return 32'(i) * 32'h0101_0101 + 32'h1000_0000;
    endfunction

    task automatic apply(input string name, input logic r, input logic rw,
                         input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        exp_t x;
        @(negedge clk);
        rst            = r;
        bus.reg_write  = rw;
        bus.write_reg  = wr;
        bus.write_data = wd;
        bus.read_reg1  = r1;
        bus.read_reg2  = r2;
        x.e1 = e1;
        x.e2 = e2;
        sb.push_back(x);
        #1;
        e = sb.pop_front();
        n_vec++;
        if (bus.read_data1 !== e.e1) begin
            n_err++;
            $display("FAIL %s rd1: got %h expected %h", name, bus.read_data1, e.e1);
        end
        if (bus.read_data2 !== e.e2) begin
            n_err++;
            $display("FAIL %s rd2: got %h expected %h", name, bus.read_data2, e.e2);
        end
    endtask

    initial begin
        bus.reg_write  = 1'b0;
        bus.write_reg  = '0;
        bus.write_data = '0;
        bus.read_reg1  = '0;
        bus.read_reg2  = '0;

        tbl[0]  = mk(1, 0,  0, 32'h0,        0,  0, 32'h0, 32'h0);
        tbl[1]  = mk(0, 1,  5, 32'hDEADBEEF, 5,  0, pick(32'hDEADBEEF, 32'h0), 32'h0);
        tbl[2]  = mk(1, 0,  0, 32'h0,        5,  0, 32'h0, 32'h0);
        tbl[3]  = mk(0, 0,  0, 32'h0,        5,  0, 32'h0, 32'h0);
        tbl[4]  = mk(0, 1,  8, 32'h12345678, 8,  5, pick(32'h12345678, 32'h0), 32'h0);
        tbl[5]  = mk(0, 0,  8, 32'hFFFFFFFF, 8,  8, 32'h12345678, 32'h12345678);
        tbl[6]  = mk(0, 1,  0, 32'hFFFFFFFF, 0,  0, 32'h0, 32'h0);
        tbl[7]  = mk(0, 0,  0, 32'h0,        0,  8, 32'h0, 32'h12345678);
        tbl[8]  = mk(0, 1, 31, 32'h00400008, 8, 31, 32'h12345678, pick(32'h00400008, 32'h0));
        tbl[9]  = mk(0, 0,  0, 32'h0,       31, 31, 32'h00400008, 32'h00400008);
        tbl[10] = mk(1, 1,  3, 32'hAAAA5555, 3, 31, 32'h0, 32'h0);
        tbl[11] = mk(0, 0,  0, 32'h0,        3, 31, 32'h0, 32'h0);
        tbl[12] = mk(0, 1,  1, 32'h11,       1,  2, pick(32'h11, 32'h0), 32'h0);
        tbl[13] = mk(0, 1,  2, 32'h22,       2,  1, pick(32'h22, 32'h0), 32'h11);
        tbl[14] = mk(0, 0,  0, 32'h0,        2,  1, 32'h22, 32'h11);
        tbl[15] = mk(0, 0,  0, 32'h0,        1,  1, 32'h11, 32'h11);
        tbl[16] = mk(0, 1,  4, 32'hA,        4,  0, pick(32'hA, 32'h0), 32'h0);
        tbl[17] = mk(0, 1,  4, 32'hB,        4,  4, pick(32'hB, 32'hA), pick(32'hB, 32'hA));
        tbl[18] = mk(0, 0,  0, 32'h0,        4,  4, 32'hB, 32'hB);

        for (int i = 0; i < 19; i++)
            apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].rw, tbl[i].wr, tbl[i].wd,
                  tbl[i].r1, tbl[i].r2, tbl[i].e1, tbl[i].e2);

        // Clean slate, fill every register, then one rst cycle must wipe all of them.
        apply("pre_rst", 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int i = 1; i < 32; i++)
            apply($sformatf("fill%0d", i), 0, 1, 5'(i), fill_val(i), 5'(i), 5'(i - 1),
                  pick(fill_val(i), 32'h0), (i == 1) ? 32'h0 : fill_val(i - 1));
        apply("fill_chk", 0, 0, 0, 32'h0, 31, 16, fill_val(31), fill_val(16));
        apply("mid_rst", 1, 1, 7, 32'hCAFEF00D, 31, 7, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++)
            apply($sformatf("clr%0d", i), 0, 0, 0, 32'h0, 5'(2 * i), 5'(2 * i + 1),
                  32'h0, 32'h0);

        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic        rw;
            logic [4:0]  wr;
            logic [4:0]  r1;
            logic [4:0]  r2;
            logic [31:0] wd;
            r  = ($urandom_range(0, 19) == 0);
            rw = ($urandom_range(0, 3) != 0);
            wr = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            apply($sformatf("rnd%0d", i), r, rw, wr, wd, r1, r2,
                  model_read(r1, r, rw, wr, wd), model_read(r2, r, rw, wr, wd));
            if (r)
                for (int k = 0; k < 32; k++) model[k] = 32'h0;
            else if (rw && wr != 5'd0)
                model[wr] = wd;
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
